pr_req_latch: RTL and testbench

- Request capture and arbitration stage for sticky, prioritised request handling.
- Captures single-cycle request pulses from NUM_SIZE sources into a sticky pending vector.
- Selects the highest-index pending source.
- Presents that index to a downstream consumer over a valid/ready handshake, and retires the served bit on acceptance.
- Sits between raw event sources and the consumer of encoded request indices.

---
 rtl/pr_req_latch.sv | 85 ++++++++
 tb/tb_pr_req_latch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pr_req_latch.sv
// Sticky request capture with highest-index selection, presented to a consumer
// over valid/ready; the served bit retires on acceptance.
module pr_req_latch #(
  parameter int NUM_SIZE = 8,
  parameter int OUT_SIZE = $clog2(NUM_SIZE),
  parameter int CNT_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SIZE-1:0] req,
  input  logic                clr,
  output logic                out_valid,
  output logic [OUT_SIZE-1:0] out_idx,
  input  logic                out_ready,
  output logic [NUM_SIZE-1:0] pending,
  output logic [CNT_SIZE-1:0] lost_cnt
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              state, state_nxt;
  logic [OUT_SIZE-1:0] idx_nxt;
  logic [NUM_SIZE-1:0] ack, rem, pending_nxt;
  logic                handshake, collide;

  function automatic logic [OUT_SIZE-1:0] select_top(input logic [NUM_SIZE-1:0] v);
    logic [OUT_SIZE-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_SIZE; i++) begin
      if (v[i]) sel = OUT_SIZE'(i);
    end
    return sel;
  endfunction

  assign out_valid = (state == OFFER);
  assign handshake = out_valid & out_ready;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    ack         = '0;
    if (handshake) ack = NUM_SIZE'(1) << out_idx;
    rem         = pending & ~ack;
    pending_nxt = rem | req;
    collide     = |(req & pending & ~ack);
    state_nxt   = state;
    idx_nxt     = out_idx;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          idx_nxt   = select_top(pending);
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        // Offer is held until accepted; later arrivals wait even if higher.
        if (handshake) begin
          if (|rem) idx_nxt = select_top(rem);
          else      state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_idx  <= '0;
      pending  <= '0;
      lost_cnt <= '0;
    end else if (clr) begin
      state    <= IDLE;
      out_idx  <= '0;
      pending  <= '0;
      lost_cnt <= '0;
    end else begin
      state   <= state_nxt;
      out_idx <= idx_nxt;
      pending <= pending_nxt;
      if (collide && lost_cnt != '1) lost_cnt <= lost_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pr_req_latch.sv
// Bench for pr_req_latch: cycle-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pr_req_latch;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic [7:0] lost_cnt;

  int tests = 0;
  int fails = 0;

  pr_req_latch #(.NUM_SIZE(N), .OUT_SIZE(3), .CNT_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr),
    .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
    .pending(pending), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a set of waiting sources, one current offer, a lost tally.
  bit m_wait[N];
  bit m_valid;
  int m_idx;
  int m_lost;

  function automatic int highest(input bit s[N]);
    for (int i = N - 1; i >= 0; i--) if (s[i]) return i;
    return -1;
  endfunction

  function automatic int pend_word();
    int w = 0;
    for (int i = 0; i < N; i++) if (m_wait[i]) w += (1 << i);
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      foreach (m_wait[i]) m_wait[i] = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_lost  = 0;
    end else begin
      bit left[N];
      bit took;
      bit hit;
      took = m_valid && out_ready;
      hit  = 1'b0;
      foreach (left[i]) left[i] = m_wait[i] && !(took && i == m_idx);
      foreach (left[i]) if (req[i] && left[i]) hit = 1'b1;
      if (hit && m_lost < 255) m_lost++;
      if (!m_valid) begin
        if (highest(m_wait) >= 0) begin
          m_valid = 1'b1;
          m_idx   = highest(m_wait);
        end
      end else if (took) begin
        if (highest(left) >= 0) m_idx = highest(left);
        else m_valid = 1'b0;
      end
      foreach (m_wait[i]) m_wait[i] = left[i] || req[i];
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", int'(out_valid), int'(m_valid));
      check("pending", int'(pending), pend_word());
      check("lost_cnt", int'(lost_cnt), m_lost);
      if (m_valid) check("out_idx", int'(out_idx), m_idx);
    end
  end

  // Drive inputs for one cycle; returns at the following negedge.
  task automatic step(input logic [7:0] r, input logic c, input logic rd);
    req = r; clr = c; out_ready = rd;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    #2;
    check("reset_valid", int'(out_valid), 0);
    check("reset_pending", int'(pending), 0);
    check("reset_lost", int'(lost_cnt), 0);
    check("reset_idx", int'(out_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pulse, full latency path.
    step(8'h04, 1'b0, 1'b1);
    check("t1_pending", int'(pending), 8'h04);
    check("t1_valid_early", int'(out_valid), 0);
    step(8'h00, 1'b0, 1'b1);
    check("t1_valid", int'(out_valid), 1);
    check("t1_idx", int'(out_idx), 2);
    step(8'h00, 1'b0, 1'b1);
    check("t1_done_pending", int'(pending), 0);
    check("t1_done_valid", int'(out_valid), 0);

    // Back-to-back service 7, 4, 0.
    step(8'h91, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    check("t2_idx7", int'(out_idx), 7);
    step(8'h00, 1'b0, 1'b1);
    check("t2_idx4", int'(out_idx), 4);
    check("t2_valid4", int'(out_valid), 1);
    step(8'h00, 1'b0, 1'b1);
    check("t2_idx0", int'(out_idx), 0);
    check("t2_valid0", int'(out_valid), 1);
    step(8'h00, 1'b0, 1'b1);
    check("t2_idle", int'(out_valid), 0);

    // No preemption by a higher arrival.
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("t3_idx3", int'(out_idx), 3);
    step(8'h80, 1'b0, 1'b0);
    check("t3_hold", int'(out_idx), 3);
    check("t3_pending", int'(pending), 8'h88);
    step(8'h00, 1'b0, 1'b1);
    check("t3_next7", int'(out_idx), 7);
    check("t3_valid7", int'(out_valid), 1);
    step(8'h00, 1'b0, 1'b1);
    check("t3_idle", int'(out_valid), 0);

    // Re-request in the handshake cycle: set wins, no loss counted.
    step(8'h20, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("t4_idx5", int'(out_idx), 5);
    step(8'h20, 1'b0, 1'b1);
    check("t4_pending", int'(pending), 8'h20);
    check("t4_lost", int'(lost_cnt), 0);
    step(8'h00, 1'b0, 1'b0);
    check("t4_reoffer_valid", int'(out_valid), 1);
    check("t4_reoffer_idx", int'(out_idx), 5);

    // Lost counter saturation.
    step(8'h00, 1'b1, 1'b0);
    step(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(8'h01, 1'b0, 1'b0);
      if (i == 9) check("t5_lost10", int'(lost_cnt), 10);
    end
    check("t5_lost_sat", int'(lost_cnt), 255);

    // Clear during offer discards simultaneous req and handshake.
    step(8'hFF, 1'b1, 1'b1);
    check("t6_pending", int'(pending), 0);
    check("t6_valid", int'(out_valid), 0);
    check("t6_lost", int'(lost_cnt), 0);

    // Asynchronous reset mid-offer.
    step(8'h40, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("t7_valid_pre", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_valid", int'(out_valid), 0);
    check("t7_pending", int'(pending), 0);
    check("t7_idx", int'(out_idx), 0);
    check("t7_lost", int'(lost_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(r, ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0));
    end
    step(8'h00, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
